// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter for a shared 4:1 selection datapath. It grants the mux
// select lines to one of four requesters at a time. An owner keeps the grant
// for at most HOLD_MAX consecutive cycles while anyone else is waiting. The
// selected channel data is registered one cycle after the grant.
//
// Parameters:
//   W         data width of each channel and of dout
//   HOLD_MAX  max consecutive grant cycles under contention (1..255)
//
// Ports:
//   clk         single clock, all state on the rising edge
//   rst_n       asynchronous active-low reset
//   req[3:0]    level-sensitive per-channel requests
//   din0..din3  channel data inputs
//   gnt[3:0]    registered one-hot grant, all-zero when idle
//   sel[1:0]    registered binary index of the current or last owner
//   busy        high while in the GRANT state
//   dout        registered din[sel], loaded on every granted cycle
//   dout_valid  registered copy of (gnt != 0)
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int W        = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic [W-1:0] din2,
  input  logic [W-1:0] din3,
  output logic [3:0]   gnt,
  output logic [1:0]   sel,
  output logic         busy,
  output logic [W-1:0] dout,
  output logic         dout_valid
);

  localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t       state_r;
  state_t       state_n_s;
  logic [3:0]   gnt_r;
  logic [3:0]   gnt_n_s;
  logic [1:0]   sel_r;
  logic [1:0]   sel_n_s;
  logic [1:0]   last_r;
  logic [1:0]   last_n_s;
  logic [7:0]   hold_cnt_r;
  logic [7:0]   hold_n_s;
  logic         busy_r;
  logic [W-1:0] dout_r;
  logic         dout_valid_r;
  logic [3:0]   others_s;
  logic [3:0]   pick_src_s;
  logic [1:0]   win_s;
  logic [W-1:0] din_sel_s;

  // First set bit of cand, searching upward from after+1 and wrapping.
  // Callers only use the result when cand is non-zero.
  function automatic logic [1:0] rr_pick(input logic [3:0] cand,
                                         input logic [1:0] after);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = after + 2'd1;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = after + 2'(k);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Requests from everyone but the owner, and the winner of the search.
  // In GRANT last_r is the current owner; searching only others_s keeps a
  // forcibly rotated owner from being re-granted on the same edge.
  always_comb begin
    others_s   = req & ~(4'b0001 << last_r);
    pick_src_s = (state_r == ST_IDLE) ? req : others_s;
    win_s      = rr_pick(pick_src_s, last_r);
  end

  // Next-state and next-grant decision.
  always_comb begin
    state_n_s = state_r;
    gnt_n_s   = gnt_r;
    sel_n_s   = sel_r;
    last_n_s  = last_r;
    hold_n_s  = hold_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          state_n_s = ST_GRANT;
          gnt_n_s   = 4'b0001 << win_s;
          sel_n_s   = win_s;
          last_n_s  = win_s;
          hold_n_s  = 8'd1;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (req[last_r] && ((hold_cnt_r < HOLD_MAX_C) || (others_s == 4'b0000))) begin
          // Keep the owner; the counter saturates so an uncontested owner
          // can hold forever without wrapping.
          if (hold_cnt_r < HOLD_MAX_C) begin
            hold_n_s = hold_cnt_r + 8'd1;
          end else begin
            hold_n_s = hold_cnt_r;
          end
        end else if (others_s != 4'b0000) begin
          // Forced rotation or voluntary handover, both without a bubble.
          gnt_n_s  = 4'b0001 << win_s;
          sel_n_s  = win_s;
          last_n_s = win_s;
          hold_n_s = 8'd1;
        end else begin
          // Nobody left; sel and last keep their values.
          state_n_s = ST_IDLE;
          gnt_n_s   = 4'b0000;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        gnt_n_s   = 4'b0000;
      end
    endcase
  end

  // Mux of channel data by the registered select.
  always_comb begin
    case (sel_r)
      2'd0:    din_sel_s = din0;
      2'd1:    din_sel_s = din1;
      2'd2:    din_sel_s = din2;
      2'd3:    din_sel_s = din3;
      default: din_sel_s = din0;
    endcase
  end

  // State, grant and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      gnt_r        <= 4'b0000;
      sel_r        <= 2'd0;
      last_r       <= 2'd3;   // channel 0 searched first after reset
      hold_cnt_r   <= 8'd0;
      busy_r       <= 1'b0;
      dout_r       <= '0;
      dout_valid_r <= 1'b0;
    end else begin
      state_r      <= state_n_s;
      gnt_r        <= gnt_n_s;
      sel_r        <= sel_n_s;
      last_r       <= last_n_s;
      hold_cnt_r   <= hold_n_s;
      busy_r       <= (state_n_s == ST_GRANT);
      dout_valid_r <= (gnt_r != 4'b0000);
      if (gnt_r != 4'b0000) begin
        dout_r <= din_sel_s;
      end else begin
        dout_r <= dout_r;
      end
    end
  end

  assign gnt        = gnt_r;
  assign sel        = sel_r;
  assign busy       = busy_r;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Directed-vector bench for mux4_rr_arbiter with W=8, HOLD_MAX=4. Every
// expected value below is worked out by hand from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  localparam int W = 8;
  localparam int HM = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] din0, din1, din2, din3;
  logic [3:0]   gnt;
  logic [1:0]   sel;
  logic         busy;
  logic [W-1:0] dout;
  logic         dout_valid;

  int tests_run;
  int tests_failed;

  mux4_rr_arbiter #(.W(W), .HOLD_MAX(HM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din0       (din0),
    .din1       (din1),
    .din2       (din2),
    .din3       (din3),
    .gnt        (gnt),
    .sel        (sel),
    .busy       (busy),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse between edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    req   = 4'b0000;
    din0  = 8'hA0;
    din1  = 8'hB1;
    din2  = 8'hC2;
    din3  = 8'hD3;

    // Reset defaults.
    step();
    step();
    check_eq("rst_gnt",   32'(gnt),        32'h0);
    check_eq("rst_sel",   32'(sel),        32'h0);
    check_eq("rst_busy",  32'(busy),       32'h0);
    check_eq("rst_dout",  32'(dout),       32'h0);
    check_eq("rst_dv",    32'(dout_valid), 32'h0);
    check_eq("rst_hold",  32'(dut.hold_cnt_r), 32'h0);

    // Single request: grant after one edge, data after two.
    rst_n = 1'b1;
    req   = 4'b0001;
    step();
    check_eq("single_gnt",  32'(gnt),        32'h1);
    check_eq("single_sel",  32'(sel),        32'h0);
    check_eq("single_busy", 32'(busy),       32'h1);
    check_eq("single_dv0",  32'(dout_valid), 32'h0);
    step();
    check_eq("single_dout", 32'(dout),       32'hA0);
    check_eq("single_dv1",  32'(dout_valid), 32'h1);

    // Asynchronous reset mid-grant with no clock edge involved.
    rst_n = 1'b0;
    #1;
    check_eq("async_gnt",  32'(gnt),        32'h0);
    check_eq("async_busy", 32'(busy),       32'h0);
    check_eq("async_dout", 32'(dout),       32'h0);
    check_eq("async_dv",   32'(dout_valid), 32'h0);
    rst_n = 1'b1;

    // All-channel round robin: each channel holds exactly HM cycles.
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      check_eq($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << ((k / HM) % 4)));
      check_eq($sformatf("rr_sel%0d", k), 32'(sel), 32'((k / HM) % 4));
    end
    req = 4'b0000;
    step();
    step();
    check_eq("rr_idle_gnt", 32'(gnt),        32'h0);
    check_eq("rr_idle_dv",  32'(dout_valid), 32'h0);

    // Early release handover 0 -> 2, then idle with sel held.
    pulse_reset();
    req = 4'b0101;
    step();
    check_eq("er_gnt0", 32'(gnt), 32'h1);
    step();
    check_eq("er_gnt1", 32'(gnt), 32'h1);
    req = 4'b0100;
    step();
    check_eq("er_gnt2", 32'(gnt), 32'h4);
    check_eq("er_sel2", 32'(sel), 32'h2);
    check_eq("er_hold", 32'(dut.hold_cnt_r), 32'h1);
    step();
    check_eq("er_dout", 32'(dout), 32'hC2);
    req = 4'b0000;
    step();
    check_eq("er_idle_gnt",  32'(gnt),        32'h0);
    check_eq("er_idle_sel",  32'(sel),        32'h2);
    check_eq("er_idle_busy", 32'(busy),       32'h0);
    check_eq("er_idle_dv",   32'(dout_valid), 32'h1);
    step();
    check_eq("er_dv_fall",   32'(dout_valid), 32'h0);
    check_eq("er_dout_hold", 32'(dout),       32'hC2);
    check_eq("er_sel_hold",  32'(sel),        32'h2);

    // No forced rotation without contention; counter saturates at HM.
    req = 4'b0010;
    for (int k = 0; k < 20; k++) begin
      step();
      check_eq($sformatf("nc_gnt%0d", k), 32'(gnt), 32'h2);
    end
    check_eq("nc_hold_sat", 32'(dut.hold_cnt_r), 32'(HM));
    req = 4'b0000;
    step();
    step();

    // Priority after wrap: last=3 favours channel 0, then handover to 3.
    pulse_reset();
    req = 4'b1001;
    step();
    check_eq("wrap_gnt0", 32'(gnt), 32'h1);
    req = 4'b1000;
    step();
    check_eq("wrap_gnt3", 32'(gnt), 32'h8);
    check_eq("wrap_sel3", 32'(sel), 32'h3);
    step();
    check_eq("wrap_dout", 32'(dout), 32'hD3);
    req = 4'b0000;
    step();
    step();

    // Reset mid-grant on channel 2, then re-arbitrate from last=3.
    pulse_reset();
    req = 4'b0100;
    step();
    check_eq("mg_gnt", 32'(gnt), 32'h4);
    step();
    check_eq("mg_dv", 32'(dout_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("mg_rst_gnt", 32'(gnt),        32'h0);
    check_eq("mg_rst_dv",  32'(dout_valid), 32'h0);
    check_eq("mg_rst_sel", 32'(sel),        32'h0);
    #3;
    rst_n = 1'b1;
    req   = 4'b1100;
    step();
    check_eq("mg_rel_gnt", 32'(gnt), 32'h4);
    check_eq("mg_rel_sel", 32'(sel), 32'h2);
    req = 4'b0000;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
